// File: rtl/digit_scan_mux.sv
// digit_scan_mux: frame-snapshotted time-multiplexed digit scanner with blanking gap
module digit_scan_mux #(
  parameter int NUM_DIGITS = 5,
  parameter int DIGIT_W = 4,
  parameter int DWELL = 1024,
  parameter int BLANK = 16,
  parameter int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          scan_en,
  output logic [DIGIT_W-1:0]            digit_out,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic [IDX_W-1:0]              sel_idx,
  output logic                          blank,
  output logic                          frame_start
);
  localparam int MX = DWELL > BLANK ? DWELL : BLANK;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] DL = CW'(DWELL - 1);
  localparam logic [CW-1:0] BL = CW'(BLANK > 0 ? BLANK - 1 : 0);
  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [NUM_DIGITS*DIGIT_W-1:0] shadow, nsrc;
  logic [IDX_W-1:0] lo, hi, nidx;
  logic hit, adv, wrap;
  // lowest enabled slot and lowest enabled slot above the current one
  always_comb begin
    lo = '0;
    hi = '0;
    hit = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (digit_en[i]) lo = IDX_W'(i);
      if (digit_en[i] && i > int'(sel_idx)) begin
        hi = IDX_W'(i);
        hit = 1'b1;
      end
    end
    adv = state == ST_IDLE || (state == ST_SHOW && cnt == DL);
    wrap = state == ST_IDLE || !hit;
    nidx = wrap ? lo : hi;
    nsrc = wrap ? digits_in : shadow;
  end
  // scan sequencer with registered outputs; a wrap or fresh start snapshots the digits
  always_ff @(posedge clk) begin
    frame_start <= 1'b0;
    if (reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      shadow <= '0;
      sel_idx <= '0;
      digit_out <= '0;
      digit_sel <= '0;
      blank <= 1'b1;
    end else if (!scan_en || (adv && digit_en == '0)) begin
      state <= ST_IDLE;
      cnt <= '0;
      digit_out <= '0;
      digit_sel <= '0;
      blank <= 1'b1;
    end else if (adv) begin
      sel_idx <= nidx;
      cnt <= '0;
      frame_start <= wrap;
      if (wrap) shadow <= digits_in;
      if (BLANK == 0) begin
        state <= ST_SHOW;
        blank <= 1'b0;
        digit_sel <= NUM_DIGITS'(1) << nidx;
        digit_out <= nsrc[nidx*DIGIT_W +: DIGIT_W];
      end else begin
        state <= ST_BLANK;
        blank <= 1'b1;
        digit_sel <= '0;
        digit_out <= '0;
      end
    end else if (state == ST_BLANK && cnt == BL) begin
      state <= ST_SHOW;
      cnt <= '0;
      blank <= 1'b0;
      digit_sel <= NUM_DIGITS'(1) << sel_idx;
      digit_out <= shadow[sel_idx*DIGIT_W +: DIGIT_W];
    end else cnt <= cnt + 1'b1;
  end
endmodule

// File: tb/tb_digit_scan_mux.sv
// tb_digit_scan_mux: randomized and directed check of two scanner configurations against a slot-window model
module tb_digit_scan_mux;
  logic clk = 0, reset = 1, scan_en = 0;
  logic [19:0] digits_in = '0;
  logic [4:0] digit_en = '0;
  logic [3:0] d0, d1;
  logic [4:0] s0, s1;
  logic [2:0] i0, i1;
  logic b0, b1, f0, f1;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed {logic run; logic [2:0] idx; logic [7:0] pos; logic [19:0] sh; logic fs;} mst_t;
  mst_t m0 = '0, m1 = '0;
  always #5 clk = ~clk;
  digit_scan_mux #(.NUM_DIGITS(5), .DIGIT_W(4), .DWELL(4), .BLANK(2)) u0 (
    .clk(clk), .reset(reset), .digits_in(digits_in), .digit_en(digit_en), .scan_en(scan_en),
    .digit_out(d0), .digit_sel(s0), .sel_idx(i0), .blank(b0), .frame_start(f0));
  digit_scan_mux #(.NUM_DIGITS(5), .DIGIT_W(4), .DWELL(1), .BLANK(0)) u1 (
    .clk(clk), .reset(reset), .digits_in(digits_in), .digit_en(digit_en), .scan_en(scan_en),
    .digit_out(d1), .digit_sel(s1), .sel_idx(i1), .blank(b1), .frame_start(f1));
  function automatic logic [2:0] lowest(logic [4:0] en);
    for (int i = 0; i < 5; i++) if (en[i]) return 3'(i);
    return 3'd0;
  endfunction
  // each enabled slot owns a window of bl+dw cycles: bl blank cycles then dw shown cycles
  function automatic mst_t step(mst_t m, int bl, int dw, logic rs, logic se, logic [4:0] en, logic [19:0] din);
    mst_t n = m;
    bit found = 0;
    n.fs = 0;
    if (rs) n = '0;
    else if (!se) n.run = 0;
    else if (!m.run) begin
      if (en != 0) begin
        n.run = 1; n.idx = lowest(en); n.pos = 0; n.sh = din; n.fs = 1;
      end
    end else if (int'(m.pos) == bl + dw - 1) begin
      if (en == 0) n.run = 0;
      else begin
        for (int i = int'(m.idx) + 1; i < 5; i++) if (en[i] && !found) begin n.idx = 3'(i); found = 1; end
        if (!found) begin n.idx = lowest(en); n.sh = din; n.fs = 1; end
        n.pos = 0;
      end
    end else n.pos = m.pos + 1;
    return n;
  endfunction
  function automatic logic [10:0] expo(mst_t m, int bl);
    logic bk = !m.run || int'(m.pos) < bl;
    logic [19:0] sh = m.sh;
    return {bk, bk ? 5'd0 : 5'd1 << m.idx, bk ? 4'd0 : sh[m.idx*4 +: 4], m.fs};
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  always @(posedge clk) begin
    m0 = step(m0, 2, 4, reset, scan_en, digit_en, digits_in);
    m1 = step(m1, 0, 1, reset, scan_en, digit_en, digits_in);
  end
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("u0_out", {21'd0, b0, s0, d0, f0}, {21'd0, expo(m0, 2)});
      chk("u1_out", {21'd0, b1, s1, d1, f1}, {21'd0, expo(m1, 0)});
      if (m0.run) chk("u0_idx", {29'd0, i0}, {29'd0, m0.idx});
      if (m1.run) chk("u1_idx", {29'd0, i1}, {29'd0, m1.idx});
    end
  end
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
    chk(nm, act, exp);
  endtask
  task automatic restart(logic [4:0] en);
    reset = 1; tick(2);
    reset = 0; scan_en = 1; digit_en = en; tick();
  endtask
  initial begin
    tick(2);
    lit("rst_vals", {b0, s0, d0, f0, i0}, {1'b1, 5'd0, 4'd0, 1'b0, 3'd0});
    digits_in = {4'h2, 4'h1, 4'hA, 4'h5, 4'h9};
    restart(5'b11111);
    lit("c0_fs", {f0, b0}, 2'b11);
    lit("u1_c0", {s1, d1, f1}, {5'b00001, 4'h9, 1'b1});
    tick(2);
    lit("c2_show", {s0, d0, f0}, {5'b00001, 4'h9, 1'b0});
    tick(6);
    lit("c8_slot1", {s0, d0}, {5'b00010, 4'h5});
    tick(6);
    lit("c14_slot2", {s0, d0}, {5'b00100, 4'hA});
    digits_in[3:0] = 4'h3;
    tick(16);
    lit("c30_fs", {f0, b0}, 2'b11);
    tick(2);
    lit("c32_new", {s0, d0}, {5'b00001, 4'h3});
    restart(5'b10010);
    lit("e_c0", {f0, b0, i0}, {2'b11, 3'd1});
    tick(2);
    lit("e_c2", {i0, d0}, {3'd1, 4'h5});
    tick(6);
    lit("e_c8", {i0, d0}, {3'd4, 4'h2});
    tick(4);
    lit("e_c12", {f0, i0}, {1'b1, 3'd1});
    restart(5'b11111);
    tick(21);
    scan_en = 0; tick();
    lit("drop", {b0, s0}, {1'b1, 5'd0});
    scan_en = 1; tick();
    lit("reen", {f0, b0, i0}, {2'b11, 3'd0});
    tick();
    reset = 1; tick();
    lit("rst_blank", {b0, s0, d0, f0, i0}, {1'b1, 5'd0, 4'd0, 1'b0, 3'd0});
    reset = 0; tick(4);
    reset = 1; tick();
    lit("rst_show", {b0, s0, d0, f0, i0}, {1'b1, 5'd0, 4'd0, 1'b0, 3'd0});
    reset = 0; digit_en = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lit("en0_idle", {b0, b1, f0, f1}, 4'b1100);
    end
    digit_en = 5'b00100; tick();
    for (int i = 0; i < 10; i++) begin
      lit("single", {s1, f1}, {5'b00100, 1'b1});
      tick();
    end
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 199) == 0;
      if ($urandom_range(0, 59) == 0) scan_en = ~scan_en;
      else if (!scan_en && $urandom_range(0, 9) == 0) scan_en = 1;
      if ($urandom_range(0, 24) == 0) digit_en = 5'($urandom);
      if ($urandom_range(0, 7) == 0) digits_in = 20'($urandom);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
